// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the unified memory port arbiter.
//   arb_state_t : transaction sequencer states (IDLE, ISSUE, WAIT)
//   SEL_IF/SEL_DM : encodings of the address/wdata mux select (mem_sel)
//   LAT_W       : width of the latency and starvation counters (values 0..15)
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam logic SEL_IF = 1'b0;
    localparam logic SEL_DM = 1'b1;

    localparam int LAT_W = 4;

endpackage

// File: rtl/mem_lat_timer.sv
// -----------------------------------------------------------------------------
// mem_lat_timer
// Loadable down-counter that times the memory latency of one transaction.
// The count stops at zero; done is high whenever the count is zero.
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous, active-high reset (count -> 0)
//   load     : load load_val this cycle (has priority over counting)
//   load_val : value to load
//   done     : count has reached zero
// -----------------------------------------------------------------------------
module mem_lat_timer
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic             done
);

    logic [LAT_W-1:0] lat_cnt;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_cnt <= '0;
        end else if (load) begin
            lat_cnt <= load_val;
        end else if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
        end
    end

    assign done = (lat_cnt == '0);

endmodule

// File: rtl/mux2.sv
// -----------------------------------------------------------------------------
// mux2
// Team 2:1 mux primitive used in front of the memory address/wdata inputs.
// Ports:
//   sel : 0 selects a, 1 selects b
//   a   : input word for sel = 0
//   b   : input word for sel = 1
//   y   : selected word
// -----------------------------------------------------------------------------
module mux2 #(
    parameter int W = 32
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single unified memory port between instruction fetch (IF) and
// data access (DM). Each transaction is granted, issued for one cycle
// (mem_en), waits MEM_LAT cycles and completes with a one-cycle valid pulse
// whose rdata is a combinational pass-through of mem_rdata. DM has priority
// unless IF has waited through STARVE_MAX consecutive DM grants.
//
// Optional build macro: ARB_STATS_EN adds saturating 16-bit counters
// if_gnt_cnt, dm_gnt_cnt and stall_cnt (cycles with a request pending but not
// granted). Without it the ports are absent and arbitration is identical.
//
// Ports:
//   clk, reset               : clock (rising edge), async active-high reset
//   if_req/if_addr           : fetch request, address sampled on grant
//   if_gnt/if_valid/if_rdata : fetch accept, completion, fetched word
//   dm_req/dm_we/dm_addr/dm_wdata : data request (store when dm_we), sampled on grant
//   dm_gnt/dm_valid/dm_rdata : data accept, completion, load data (0 for stores)
//   mem_sel                  : mux select (SEL_IF/SEL_DM), held per transaction
//   mem_en/mem_we            : one-cycle issue strobe, write enable qualified by mem_en
//   mem_addr/mem_wdata       : latched address and store data
//   mem_rdata                : memory read data
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_sel,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       if_gnt_cnt,
    output logic [15:0]       dm_gnt_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    // The WAIT countdown starts from MEM_LAT-1 so completion lands exactly
    // MEM_LAT cycles after the issue cycle (MEM_LAT=1 completes right after ISSUE).
    localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(MEM_LAT - 1);
    localparam logic [LAT_W-1:0] STARVE_LIM = LAT_W'(STARVE_MAX);

    arb_state_t        state;
    logic              cur_we;      // store flag of the in-flight transaction
    logic              lat_done;
    logic              complete;
    logic              can_grant;
    logic              if_force;
    logic [LAT_W-1:0]  starve_cnt;
    logic [ADDR_W-1:0] next_addr;
    logic [DATA_W-1:0] next_wdata;

    mem_lat_timer u_lat_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (state == ISSUE),
        .load_val (LAT_LOAD),
        .done     (lat_done)
    );

    assign complete  = (state == WAIT) && lat_done;
    assign can_grant = !reset && ((state == IDLE) || complete);
    assign if_force  = if_req && (starve_cnt == STARVE_LIM);

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        dm_gnt = 1'b0;
        if_gnt = 1'b0;
        if (can_grant) begin
            if (dm_req && !if_force) begin
                dm_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    // The muxes steer with the select that is about to be registered, so the
    // captured address/wdata always match the mem_sel of the new transaction.
    mux2 #(.W(ADDR_W)) u_addr_mux (
        .sel (dm_gnt),
        .a   (if_addr),
        .b   (dm_addr),
        .y   (next_addr)
    );

    mux2 #(.W(DATA_W)) u_wdata_mux (
        .sel (dm_gnt),
        .a   ('0),
        .b   (dm_wdata),
        .y   (next_wdata)
    );

    // Sequencer with registered memory-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mem_sel   <= SEL_IF;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cur_we    <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;

            case (state)
                IDLE:    if (if_gnt || dm_gnt) state <= ISSUE;
                ISSUE:   state <= WAIT;
                WAIT:    if (complete) state <= (if_gnt || dm_gnt) ? ISSUE : IDLE;
                default: state <= IDLE;
            endcase

            if (if_gnt || dm_gnt) begin
                mem_sel   <= dm_gnt ? SEL_DM : SEL_IF;
                mem_en    <= 1'b1;
                mem_we    <= dm_gnt && dm_we;
                cur_we    <= dm_gnt && dm_we;
                mem_addr  <= next_addr;
                mem_wdata <= next_wdata;
            end
        end
    end

    // Completion pulses; data is passed straight through from memory.
    assign if_valid = complete && (mem_sel == SEL_IF);
    assign dm_valid = complete && (mem_sel == SEL_DM);
    assign if_rdata = if_valid ? mem_rdata : '0;
    assign dm_rdata = (dm_valid && !cur_we) ? mem_rdata : '0;

    // Counts DM wins while IF is waiting; reaching the limit forces IF ahead.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (if_gnt || !if_req) begin
            starve_cnt <= '0;
        end else if (dm_gnt && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + LAT_W'(1);
        end
    end

`ifdef ARB_STATS_EN
    logic stall;

    assign stall = (if_req && !if_gnt) || (dm_req && !dm_gnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_gnt_cnt <= '0;
            dm_gnt_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (if_gnt && (if_gnt_cnt != 16'hFFFF)) if_gnt_cnt <= if_gnt_cnt + 16'd1;
            if (dm_gnt && (dm_gnt_cnt != 16'hFFFF)) dm_gnt_cnt <= dm_gnt_cnt + 16'd1;
            if (stall  && (stall_cnt  != 16'hFFFF)) stall_cnt  <= stall_cnt  + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=4).
// A transaction-level reference model (one in-flight transaction with a grant
// cycle and a completion cycle, plus a starvation counter) predicts every
// output each cycle. Directed scenarios are followed by randomized traffic.
// Build with ARB_STATS_EN defined to also check the statistics counters.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_valid;
    logic [31:0] dm_rdata;
    logic        mem_sel;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef ARB_STATS_EN
    logic [15:0] if_gnt_cnt;
    logic [15:0] dm_gnt_cnt;
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_valid   (if_valid),
        .if_rdata   (if_rdata),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_gnt     (dm_gnt),
        .dm_valid   (dm_valid),
        .dm_rdata   (dm_rdata),
        .mem_sel    (mem_sel),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef ARB_STATS_EN
        ,
        .if_gnt_cnt (if_gnt_cnt),
        .dm_gnt_cnt (dm_gnt_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    // Staged requester inputs, applied just after each rising edge.
    logic        s_if_req, s_dm_req, s_dm_we;
    logic [31:0] s_if_addr, s_dm_addr, s_dm_wdata;
    bit          dm_persist;
    bit          rand_mode;

    // Reference model state.
    int          cyc;
    bit          act;
    int          act_g;
    int          act_done;
    bit          act_sel;
    bit          act_we;
    bit          last_sel;
    logic [31:0] last_addr;
    logic [31:0] last_wdata;
    int          starve;

    int          n_checks;
    int          n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
    endtask

    task automatic model_reset();
        cyc        = 0;
        act        = 0;
        last_sel   = 0;
        last_addr  = '0;
        last_wdata = '0;
        starve     = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_if_gnt"},    if_gnt,    0);
        check({tag, "_dm_gnt"},    dm_gnt,    0);
        check({tag, "_if_valid"},  if_valid,  0);
        check({tag, "_dm_valid"},  dm_valid,  0);
        check({tag, "_if_rdata"},  if_rdata,  0);
        check({tag, "_dm_rdata"},  dm_rdata,  0);
        check({tag, "_mem_sel"},   mem_sel,   0);
        check({tag, "_mem_en"},    mem_en,    0);
        check({tag, "_mem_we"},    mem_we,    0);
        check({tag, "_mem_addr"},  mem_addr,  0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    // One clock cycle: apply staged inputs, compare against the model, advance it.
    task automatic step();
        bit ok, comp, en, g_dm, g_if;
        @(posedge clk);
        #1;
        if_req    = s_if_req;
        if_addr   = s_if_addr;
        dm_req    = s_dm_req;
        dm_we     = s_dm_we;
        dm_addr   = s_dm_addr;
        dm_wdata  = s_dm_wdata;
        mem_rdata = $urandom;
        @(negedge clk);

        ok   = !act || (cyc == act_done);
        comp = act && (cyc == act_done);
        en   = act && (cyc == act_g + 1);
        g_dm = ok && dm_req && !(if_req && starve == STARVE_MAX);
        g_if = ok && if_req && !g_dm;

        check("if_gnt",    if_gnt,    g_if);
        check("dm_gnt",    dm_gnt,    g_dm);
        check("if_valid",  if_valid,  comp && !act_sel);
        check("dm_valid",  dm_valid,  comp && act_sel);
        check("if_rdata",  if_rdata,  (comp && !act_sel) ? mem_rdata : 32'd0);
        check("dm_rdata",  dm_rdata,  (comp && act_sel && !act_we) ? mem_rdata : 32'd0);
        check("mem_en",    mem_en,    en);
        check("mem_we",    mem_we,    en && act_we);
        check("mem_sel",   mem_sel,   last_sel);
        check("mem_addr",  mem_addr,  last_addr);
        check("mem_wdata", mem_wdata, last_wdata);

        if (comp) act = 0;
        if (g_dm || g_if) begin
            act        = 1;
            act_g      = cyc;
            act_done   = cyc + 1 + MEM_LAT;
            act_sel    = g_dm;
            act_we     = g_dm && dm_we;
            last_sel   = g_dm;
            last_addr  = g_dm ? dm_addr : if_addr;
            last_wdata = g_dm ? dm_wdata : 32'd0;
        end
        if (g_if || !if_req) starve = 0;
        else if (g_dm && starve < STARVE_MAX) starve++;

        // Requesters release after their grant (DM may immediately re-request).
        if (g_if) s_if_req = 0;
        if (g_dm) begin
            s_dm_req   = dm_persist;
            s_dm_addr  = $urandom;
            s_dm_wdata = $urandom;
        end
        if (rand_mode) begin
            if (s_if_req && !g_if && $urandom_range(0, 19) == 0) s_if_req = 0;
            if (s_dm_req && !g_dm && $urandom_range(0, 19) == 0) s_dm_req = 0;
            if (!s_if_req && $urandom_range(0, 2) == 0) begin
                s_if_req  = 1;
                s_if_addr = $urandom;
            end
            if (!s_dm_req && $urandom_range(0, 2) == 0) begin
                s_dm_req   = 1;
                s_dm_we    = $urandom_range(0, 1);
                s_dm_addr  = $urandom;
                s_dm_wdata = $urandom;
            end
        end
        cyc++;
    endtask

    // Asynchronous reset asserted in the middle of the next cycle.
    task automatic reset_mid(input string tag);
        @(posedge clk);
        #1;
        s_if_req  = 0;
        s_dm_req  = 0;
        if_req    = 0;
        dm_req    = 0;
        mem_rdata = $urandom;
        #1;
        reset = 1;
        #1;
        check_all_zero(tag);
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        model_reset();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int dm_before, dm_after;
    bit seen_if;

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        dm_persist = 0;
        rand_mode  = 0;
        s_if_req   = 0;
        s_dm_req   = 0;
        s_dm_we    = 0;
        s_if_addr  = '0;
        s_dm_addr  = '0;
        s_dm_wdata = '0;
        if_req     = 0;
        dm_req     = 0;
        dm_we      = 0;
        if_addr    = '0;
        dm_addr    = '0;
        dm_wdata   = '0;
        mem_rdata  = 32'hA5A5_5A5A;
        cyc        = 0;
        reset      = 1;
        #12;
        check_all_zero("por");
        @(negedge clk);
        reset = 0;
        model_reset();

        // IF and DM load together: DM first, IF granted on DM completion.
        s_if_req  = 1; s_if_addr = 32'h0040_0004;
        s_dm_req  = 1; s_dm_we   = 0; s_dm_addr = 32'h1001_0000;
        step();
        check("s2_dm_gnt_c0", dm_gnt, 1);
        check("s2_if_gnt_c0", if_gnt, 0);
        idle(2);
        step();
        check("s2_if_gnt_c3", if_gnt, 1);
        check("s2_dm_valid_c3", dm_valid, 1);
        step();
        check("s2_mem_en_c4", mem_en, 1);
        check("s2_mem_sel_c4", mem_sel, 0);
        step();
        step();
        check("s2_if_valid_c6", if_valid, 1);
`ifdef ARB_STATS_EN
        check("s2_if_gnt_cnt", if_gnt_cnt, 1);
        check("s2_dm_gnt_cnt", dm_gnt_cnt, 1);
        check("s2_stall_cnt",  stall_cnt,  3);
`endif
        idle(2);

        // Single fetch.
        s_if_req = 1; s_if_addr = 32'h0040_0000;
        step();
        check("s1_if_gnt_c0", if_gnt, 1);
        step();
        check("s1_mem_en_c1", mem_en, 1);
        check("s1_mem_sel_c1", mem_sel, 0);
        check("s1_mem_addr_c1", mem_addr, 32'h0040_0000);
        step();
        step();
        check("s1_if_valid_c3", if_valid, 1);
        idle(2);

        // Store.
        s_dm_req = 1; s_dm_we = 1; s_dm_addr = 32'h1001_0004; s_dm_wdata = 32'hDEAD_BEEF;
        step();
        step();
        check("s3_mem_en_c1", mem_en, 1);
        check("s3_mem_we_c1", mem_we, 1);
        check("s3_mem_addr_c1", mem_addr, 32'h1001_0004);
        check("s3_mem_wdata_c1", mem_wdata, 32'hDEAD_BEEF);
        step();
        step();
        check("s3_dm_valid_c3", dm_valid, 1);
        check("s3_dm_rdata_c3", dm_rdata, 0);
        idle(2);

        // Starvation: continuous DM traffic with IF waiting.
        dm_persist = 1;
        s_dm_req = 1; s_dm_we = 0; s_dm_addr = 32'h1001_0100;
        s_if_req = 1; s_if_addr = 32'h0040_0100;
        dm_before = 0; dm_after = 0; seen_if = 0;
        for (int i = 0; i < 60 && dm_after < 2; i++) begin
            step();
            if (dm_gnt) begin
                if (seen_if) dm_after++;
                else dm_before++;
            end
            if (if_gnt) seen_if = 1;
        end
        dm_persist = 0;
        check("s4_dm_before_if", dm_before, 4);
        check("s4_if_granted", seen_if, 1);
        check("s4_dm_resumed", dm_after, 2);
        idle(8);

        // Reset during the wait phase of a load, then a fresh request.
        s_dm_req = 1; s_dm_we = 0; s_dm_addr = 32'h1001_0200;
        step();
        step();
        reset_mid("s5_rst");
        s_dm_req = 1; s_dm_we = 0; s_dm_addr = 32'h1001_0300;
        step();
        check("s5_dm_gnt_after", dm_gnt, 1);
        idle(4);

        // Randomized traffic with one mid-run reset.
        rand_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) reset_mid("rand_rst");
            step();
        end
        rand_mode = 0;
        s_if_req = 0;
        s_dm_req = 0;
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
